main_mem_responder: RTL
=======================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 The block SHALL take parameter DEPTH_BLOCKS, default 4096, meaning number of 128-bit blocks stored (power of two; IDX_W = log2(DEPTH_BLOCKS)).
REQ-002 The block SHALL take parameter LATENCY, default 4, meaning clock edges from request acceptance to response valid (legal range 1..15).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: the cache side presents a block request.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = write-back of a dirty block, 0 = block fetch for allocation.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address; bits [3:0] ignored.
REQ-009 The block SHALL have port req_wdata, input, 128 bits: block to store; word 0 in [31:0], word 3 in [127:96].
REQ-010 The block SHALL have port req_ready, output, 1 bit: the request is accepted on an edge where req_valid and req_ready are both 1.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: the response is available.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: the cache side consumes the response on an edge where resp_valid and resp_ready are both 1.
REQ-013 The block SHALL have port resp_rdata, output, 128 bits: block contents at the request index.

Function
REQ-014 The block index SHALL be req_addr[IDX_W+3:4], so addresses beyond DEPTH_BLOCKS wrap modulo DEPTH_BLOCKS.
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 On acceptance in IDLE, the block SHALL latch req_write, the index and req_wdata, load a latency counter with LATENCY-1, and enter WAIT.
REQ-017 In WAIT with counter not equal to 0, the counter SHALL decrement each edge.
REQ-018 In WAIT with counter equal to 0, the block SHALL enter RESP with resp_valid=1 on that edge, so resp_valid rises exactly LATENCY edges after the accepting edge.
REQ-019 For a write, the array SHALL be updated on the WAIT-to-RESP edge, and resp_rdata SHALL equal the written block.
REQ-020 For a read, resp_rdata SHALL equal the array contents at the latched index, including the effect of all previously completed writes.
REQ-021 In RESP, resp_valid and resp_rdata SHALL hold stable until resp_ready=1; on that edge the FSM SHALL return to IDLE and resp_valid SHALL fall.
REQ-022 Only one request SHALL be outstanding; req_valid while not in IDLE SHALL be ignored, with no queuing.
REQ-023 req_valid and resp_ready asserted on the same edge in RESP SHALL complete the response only; the new request is accepted no earlier than the following edge.
REQ-024 Inputs other than req_* in IDLE and resp_ready in RESP SHALL have no effect.

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE, the counter 0, req_ready=1, resp_valid=0 and resp_rdata=0, asynchronously.
REQ-026 Array contents SHALL NOT be reset.
REQ-027 Reset in WAIT SHALL abort the request, and a write not yet committed SHALL leave the array unchanged.
REQ-028 Reset in RESP SHALL drop the response.

Structure
REQ-029 Package mem_pkg SHALL hold BLOCK_SIZE=128, ADDR_W=32, WORDS=4, the FSM state enum, and the helper for the counter width.
REQ-030 Storage SHALL be one sub-module, main_mem_array: a synchronous 1-read/1-write 128-bit array with no reset; the FSM stays in main_mem_responder.

Verification
REQ-031 Reset then read at addr 0x0000_0040 after a write of 0x...DEAD_BEEF there: resp_valid rises 4 edges after acceptance, and resp_rdata = the written block.
REQ-032 Write at 0x0001_0010 (index wraps to 1 for DEPTH_BLOCKS=4096), then read at 0x0000_0010: the data matches.
REQ-033 Hold resp_ready=0 for 5 cycles in RESP: resp_valid and resp_rdata stay stable, req_ready stays 0, and req_valid pulses are ignored.
REQ-034 Assert rst_n=0 two cycles into a write WAIT: outputs go to reset values at once, and a later read of that index returns the old data.
REQ-035 Run back-to-back read, write, read with resp_ready tied to 1 and LATENCY=1: each response arrives 1 edge after acceptance, and the next acceptance comes 1 edge after the response completes.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and counter sizing helper for the main memory responder.
package mem_pkg;
  localparam int BLOCK_SIZE = 128;
  localparam int ADDR_W     = 32;
  localparam int WORDS      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bits needed to hold the counter load value LATENCY-1 (at least one bit).
  function automatic int cnt_width(input int latency);
    return (latency <= 2) ? 1 : $clog2(latency);
  endfunction
endpackage

// File: rtl/main_mem_array.sv
// Block storage: synchronous 1-read/1-write array of 128-bit blocks, no reset.
module main_mem_array #(
  parameter int DEPTH = 4096,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [127:0]     wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [127:0]     rdata
);
  logic [127:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/main_mem_responder.sv
// Single-outstanding block memory responder with fixed request-to-response latency.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the response holds valid and data stable until it is consumed.
module main_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BLOCKS = 4096,
  parameter int LATENCY      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [127:0]      req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [127:0]      resp_rdata,
  output state_t            dbg_state
);
  localparam int IDX_W = $clog2(DEPTH_BLOCKS);
  localparam int CNT_W = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [127:0]     wdata_q;
  logic [127:0]     arr_rdata;
  logic             accept;
  logic             fire;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+4], req_addr[3:0]};
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt     <= CNT_LOAD;
        wr_q    <= req_write;
        idx_q   <= req_addr[IDX_W+3:4];
        wdata_q <= req_wdata;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          fire     = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Output is gated by state so reset clears it without resetting the array.
    resp_rdata = resp_valid ? (wr_q ? wdata_q : arr_rdata) : '0;
  end

  // Commit and read both happen on the WAIT-to-RESP edge, so an aborted write never lands.
  main_mem_array #(.DEPTH(DEPTH_BLOCKS)) u_array (
    .clk   (clk),
    .we    (fire & wr_q),
    .waddr (idx_q),
    .wdata (wdata_q),
    .re    (fire & ~wr_q),
    .raddr (idx_q),
    .rdata (arr_rdata)
  );
endmodule
